// File: rtl/glitch_sequencer.sv
// glitch_sequencer: arms, waits for a trigger, then times delay/width/gap through an external down-counter.
// Build option: define GLITCH_TRIGGER_SYNC_EN to pass trigger through a 2-flop synchronizer.

module glitch_sequencer #(
  parameter int PULSE_CNT_BITS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arm,
  input  logic                      abort,
  input  logic                      trigger,
  input  logic [31:0]               delayCycles,
  input  logic [31:0]               widthCycles,
  input  logic [31:0]               gapCycles,
  input  logic [PULSE_CNT_BITS-1:0] pulseCount,
  input  logic                      isZero,
  output logic [31:0]               counterValue,
  output logic                      setCounter,
  output logic                      glitchOut,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [3:0] {
    IDLE, ARMED, LOAD_DELAY, WAIT_DELAY, LOAD_WIDTH, PULSE, LOAD_GAP, WAIT_GAP, DONE
  } state_t;

  state_t                    state, state_next;
  logic [31:0]               width_sh, gap_sh;
  logic [PULSE_CNT_BITS-1:0] pulses_left, pulse_init;
  logic                      hold_q, trig, qual, last_pulse, fire;

`ifdef GLITCH_TRIGGER_SYNC_EN
  logic trig_meta, trig_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_meta <= 1'b0;
      trig_sync <= 1'b0;
    end else begin
      trig_meta <= trigger;
      trig_sync <= trig_meta;
    end
  end

  assign trig = trig_sync;
`else
  assign trig = trigger;
`endif

  // isZero still shows the pre-load count in the load cycle and the one after it.
  assign qual       = isZero & ~setCounter & ~hold_q;
  assign last_pulse = (pulses_left <= PULSE_CNT_BITS'(1));
  assign pulse_init = (pulseCount == '0) ? PULSE_CNT_BITS'(1) : pulseCount;
  assign fire       = (state == ARMED) && (state_next == LOAD_DELAY);
  assign busy       = (state != IDLE) && (state != DONE);

  always_comb begin
    // NOTE: state_next gets its default before the case so no path leaves it unassigned and infers a latch.
    state_next = state;
    case (state)
      IDLE:       if (arm) state_next = ARMED;
      ARMED: begin
        if (!arm)      state_next = IDLE;
        else if (trig) state_next = LOAD_DELAY;
      end
      LOAD_DELAY: state_next = WAIT_DELAY;
      WAIT_DELAY: if (qual) state_next = LOAD_WIDTH;
      LOAD_WIDTH: state_next = PULSE;
      PULSE:      if (qual) state_next = last_pulse ? DONE : LOAD_GAP;
      LOAD_GAP:   state_next = WAIT_GAP;
      WAIT_GAP:   if (qual) state_next = LOAD_WIDTH;
      DONE:       if (!arm) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // Outputs are registered from state_next so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      hold_q       <= 1'b0;
      width_sh     <= '0;
      gap_sh       <= '0;
      pulses_left  <= '0;
      counterValue <= '0;
      setCounter   <= 1'b0;
      glitchOut    <= 1'b0;
      done         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values, whatever the statement order.
      state      <= state_next;
      hold_q     <= setCounter;
      glitchOut  <= (state_next == PULSE);
      done       <= (state_next == DONE) && (state != DONE);
      setCounter <= 1'b0;

      if (fire) begin
        width_sh    <= widthCycles;
        gap_sh      <= gapCycles;
        pulses_left <= pulse_init;
      end
      if ((state == PULSE) && (state_next != PULSE))
        pulses_left <= pulses_left - PULSE_CNT_BITS'(1);

      case (state_next)
        LOAD_DELAY: begin
          setCounter   <= 1'b1;
          counterValue <= delayCycles;
        end
        LOAD_WIDTH: begin
          setCounter   <= 1'b1;
          counterValue <= width_sh;
        end
        LOAD_GAP: begin
          setCounter   <= 1'b1;
          counterValue <= gap_sh;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_glitch_sequencer.sv
// Self-checking bench for glitch_sequencer: a behavioural down-counter model, a table of shots,
// and hand-written sequences for reset, abort and re-arm corner cases.

module tb_glitch_sequencer;

`ifdef GLITCH_TRIGGER_SYNC_EN
  localparam int TRIG_LAT = 3;
`else
  localparam int TRIG_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        arm, abort, trigger, isZero;
  logic [31:0] delayCycles, widthCycles, gapCycles, counterValue;
  logic [7:0]  pulseCount;
  logic        setCounter, glitchOut, busy, done;

  glitch_sequencer #(.PULSE_CNT_BITS(8)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .trigger(trigger),
    .delayCycles(delayCycles), .widthCycles(widthCycles), .gapCycles(gapCycles),
    .pulseCount(pulseCount), .isZero(isZero), .counterValue(counterValue),
    .setCounter(setCounter), .glitchOut(glitchOut), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Down-counter model: load lands one edge after setCounter, isZero is registered from count==0.
  logic [31:0] cnt;
  logic        cz, hold_tb, stale_en;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      cz      <= 1'b0;
      hold_tb <= 1'b0;
    end else begin
      cnt     <= setCounter ? counterValue : cnt - 32'd1;
      cz      <= (cnt == 32'd0);
      hold_tb <= setCounter;
    end
  end
  assign isZero = cz | (stale_en & (setCounter | hold_tb));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          set_cyc[$];
  logic [31:0] set_val[$];
  int          rise_q[$];
  int          width_q[$];
  int          done_cnt = 0;
  int          done_busy = 0;
  int          last_rise = 0;
  logic        prev_g = 1'b0;

  always @(negedge clk) begin
    if (setCounter) begin
      set_cyc.push_back(cyc);
      set_val.push_back(counterValue);
    end
    if (glitchOut && !prev_g) begin
      rise_q.push_back(cyc);
      last_rise <= cyc;
    end
    if (!glitchOut && prev_g) width_q.push_back(cyc - last_rise);
    if (done) begin
      done_cnt <= done_cnt + 1;
      if (busy) done_busy <= done_busy + 1;
    end
    prev_g <= glitchOut;
  end

  function automatic int set_cyc_at(int i);
    return (i < set_cyc.size()) ? set_cyc[i] : -1;
  endfunction
  function automatic logic [31:0] set_val_at(int i);
    return (i < set_val.size()) ? set_val[i] : 32'hffff_ffff;
  endfunction
  function automatic int rise_at(int i);
    return (i < rise_q.size()) ? rise_q[i] : -1;
  endfunction
  function automatic int width_at(int i);
    return (i < width_q.size()) ? width_q[i] : -1;
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] delay;
    logic [31:0] width;
    logic [31:0] gap;
    logic [7:0]  pc;
    logic        stale;
    int          exp_pulses;
    int          exp_hi;
    int          exp_lo;
    int          exp_first;
    int          exp_sets;
  } row_t;

  row_t rows[7];

  task automatic run_shot(input row_t r, input int idx);
    int    sb, rb, wb, db, dbb, t0;
    string tag;
    tag         = $sformatf("row%0d", idx);
    delayCycles = r.delay;
    widthCycles = r.width;
    gapCycles   = r.gap;
    pulseCount  = r.pc;
    stale_en    = r.stale;
    arm         = 1'b1;
    tick(2);
    check({tag, "_busy_armed"}, busy, 1);
    sb  = set_cyc.size();
    rb  = rise_q.size();
    wb  = width_q.size();
    db  = done_cnt;
    dbb = done_busy;
    trigger = 1'b1;
    t0      = cyc;
    for (int k = 0; k < 20 && set_cyc.size() == sb; k++) tick(1);
    // Scramble the live inputs: the shot must run from its shadow copies.
    trigger     = 1'b0;
    delayCycles = 32'h0000_0777;
    widthCycles = 32'h00ab_0000;
    gapCycles   = 32'h00cd_0000;
    pulseCount  = 8'd9;
    for (int k = 0; k < 3000 && done_cnt == db; k++) tick(1);
    // Trigger held high in DONE with arm still set must not re-fire.
    trigger = 1'b1;
    tick(20);
    check({tag, "_trig_latency"}, set_cyc_at(sb) - t0, TRIG_LAT);
    check({tag, "_set_count"}, set_cyc.size() - sb, r.exp_sets);
    check({tag, "_load_delay"}, set_val_at(sb), r.delay);
    check({tag, "_load_width"}, set_val_at(sb + 1), r.width);
    if (r.exp_pulses > 1) check({tag, "_load_gap"}, set_val_at(sb + 2), r.gap);
    check({tag, "_set_spacing"}, set_cyc_at(sb + 1) - set_cyc_at(sb), r.delay + 3);
    check({tag, "_pulses"}, rise_q.size() - rb, r.exp_pulses);
    check({tag, "_first_rise"}, rise_at(rb) - set_cyc_at(sb), r.exp_first);
    for (int k = wb; k < width_q.size(); k++)
      check($sformatf("%s_width%0d", tag, k - wb), width_at(k), r.exp_hi);
    for (int k = 1; k < r.exp_pulses; k++)
      check($sformatf("%s_gap%0d", tag, k),
            rise_at(rb + k) - rise_at(rb + k - 1) - width_at(wb + k - 1), r.exp_lo);
    check({tag, "_done_count"}, done_cnt - db, 1);
    check({tag, "_busy_at_done"}, done_busy - dbb, 0);
    arm      = 1'b0;
    trigger  = 1'b0;
    stale_en = 1'b0;
    tick(4);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int sb, rb, db, a0;
    //         delay  width gap pc stale | pulses hi lo first sets
    rows[0] = '{32'd10, 32'd4, 32'd0, 8'd1, 1'b0, 1, 6, 0, 14, 2};
    rows[1] = '{32'd0,  32'd0, 32'd0, 8'd3, 1'b0, 3, 2, 4, 4,  6};
    rows[2] = '{32'd5,  32'd1, 32'd2, 8'd2, 1'b0, 2, 3, 6, 9,  4};
    rows[3] = '{32'd0,  32'd7, 32'd0, 8'd0, 1'b0, 1, 9, 0, 4,  2};
    rows[4] = '{32'd3,  32'd0, 32'd6, 8'd4, 1'b0, 4, 2, 10, 7, 8};
    rows[5] = '{32'd6,  32'd1, 32'd0, 8'd1, 1'b1, 1, 3, 0, 10, 2};
    rows[6] = '{32'd2,  32'd0, 32'd1, 8'd2, 1'b1, 2, 2, 5, 6,  4};

    arm = 1'b0; abort = 1'b0; trigger = 1'b0; stale_en = 1'b0;
    delayCycles = '0; widthCycles = '0; gapCycles = '0; pulseCount = '0;

    #1 rst = 1'b1;
    #2;
    check("reset_counterValue", counterValue, 0);
    check("reset_setCounter", setCounter, 0);
    check("reset_glitchOut", glitchOut, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    tick(2);
    rst = 1'b0;
    tick(2);

    for (int i = 0; i < 7; i++) run_shot(rows[i], i);

    // Reset asserted while the pulse is high.
    delayCycles = 32'd0; widthCycles = 32'd20; gapCycles = 32'd0; pulseCount = 8'd1;
    arm = 1'b1;
    tick(2);
    rb = rise_q.size();
    trigger = 1'b1;
    for (int k = 0; k < 40 && rise_q.size() == rb; k++) tick(1);
    trigger = 1'b0;
    tick(2);
    check("rst_pre_glitch", glitchOut, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_glitchOut", glitchOut, 0);
    check("rst_async_setCounter", setCounter, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_done", done, 0);
    check("rst_async_counterValue", counterValue, 0);
    @(negedge clk);
    arm = 1'b0;
    rst = 1'b0;
    tick(3);
    check("rst_idle_busy", busy, 0);
    sb = set_cyc.size();
    trigger = 1'b1;
    tick(6);
    trigger = 1'b0;
    check("rst_idle_no_fire", set_cyc.size() - sb, 0);
    arm = 1'b1;
    tick(2);
    check("rst_idle_to_armed", busy, 1);
    arm = 1'b0;
    tick(4);

    // Abort during the second WAIT_GAP of a 5-pulse shot; arm is dropped mid-shot first.
    delayCycles = 32'd0; widthCycles = 32'd0; gapCycles = 32'd8; pulseCount = 8'd5;
    arm = 1'b1;
    tick(2);
    sb = set_cyc.size();
    rb = rise_q.size();
    db = done_cnt;
    trigger = 1'b1;
    for (int k = 0; k < 50 && set_cyc.size() - sb < 2; k++) tick(1);
    trigger = 1'b0;
    arm     = 1'b0;
    for (int k = 0; k < 200 && set_cyc.size() - sb < 5; k++) tick(1);
    tick(2);
    check("abort_pre_busy", busy, 1);
    check("abort_pre_glitch", glitchOut, 0);
    abort = 1'b1;
    tick(1);
    check("abort_idle_busy", busy, 0);
    check("abort_idle_setCounter", setCounter, 0);
    abort = 1'b0;
    tick(40);
    check("abort_set_count", set_cyc.size() - sb, 5);
    check("abort_pulses", rise_q.size() - rb, 2);
    check("abort_no_done", done_cnt - db, 0);
    check("abort_glitch_low", glitchOut, 0);

    // Re-arming with trigger already high fires a new shot.
    delayCycles = 32'd1; widthCycles = 32'd0; gapCycles = 32'd0; pulseCount = 8'd1;
    trigger = 1'b1;
    tick(3);
    sb = set_cyc.size();
    db = done_cnt;
    arm = 1'b1;
    a0  = cyc;
    for (int k = 0; k < 10 && set_cyc.size() == sb; k++) tick(1);
    check("rearm_fire_latency", set_cyc_at(sb) - a0, 2);
    check("rearm_load_delay", set_val_at(sb), 1);
    for (int k = 0; k < 100 && done_cnt == db; k++) tick(1);
    tick(10);
    check("rearm_done_once", done_cnt - db, 1);
    check("rearm_set_count", set_cyc.size() - sb, 2);
    trigger = 1'b0;
    arm     = 1'b0;
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
